// File: rtl/nids_pkg.sv
// Shared types for the NIDS alert path: the buffered attack record and the alarm FSM states.
package nids_pkg;

    localparam int REC_TS_W    = 32;
    localparam int REC_CNT_W   = 32;
    localparam int REC_SCORE_W = 32;

    typedef struct packed {
        logic [REC_TS_W-1:0]    ts;
        logic [REC_CNT_W-1:0]   seq;
        logic [REC_SCORE_W-1:0] major;
        logic [REC_SCORE_W-1:0] minor;
    } alert_rec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        ALARM = 2'd2
    } alarm_state_e;

endpackage

// File: rtl/nids_alert_fifo.sv
// First-word fall-through record FIFO with synchronous flush; the head reads zero while empty.
module nids_alert_fifo
    import nids_pkg::*;
#(
    parameter type rec_t = alert_rec_t,
    parameter int  DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  rec_t                   i_push_data,
    input  logic                   i_pop,
    output rec_t                   o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    rec_t          r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [LW-1:0] r_level;
    logic          w_pop;
    logic          w_push;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_level = r_level;
    assign o_head  = o_empty ? '0 : r_mem[r_rd];

    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign w_pop  = i_pop && !o_empty && !i_flush;
    assign w_push = i_push && (!o_full || w_pop) && !i_flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/nids_alert_manager.sv
// Alert manager behind the PCA detector: statistics, timestamped attack records and a windowed alarm.
module nids_alert_manager
    import nids_pkg::*;
#(
    parameter int SCORE_WIDTH     = 32,
    parameter int TS_WIDTH        = 32,
    parameter int CNT_WIDTH       = 32,
    parameter int FIFO_DEPTH      = 16,
    parameter int WINDOW_CYCLES   = 1024,
    parameter int ALARM_THRESHOLD = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          in_valid,
    input  logic                          in_attack,
    input  logic [SCORE_WIDTH-1:0]        in_major_score,
    input  logic [SCORE_WIDTH-1:0]        in_minor_score,
    output logic                          rec_valid,
    input  logic                          rec_ready,
    output logic [TS_WIDTH-1:0]           rec_timestamp,
    output logic [CNT_WIDTH-1:0]          rec_seq,
    output logic [SCORE_WIDTH-1:0]        rec_major,
    output logic [SCORE_WIDTH-1:0]        rec_minor,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_WIDTH-1:0]          decision_count,
    output logic [CNT_WIDTH-1:0]          attack_count,
    output logic [CNT_WIDTH-1:0]          drop_count,
    output logic                          alarm
);

    localparam int TMR_W = $clog2(WINDOW_CYCLES + 1);
    localparam int HIT_W = $clog2(ALARM_THRESHOLD + 1);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(WINDOW_CYCLES - 1);

    typedef struct packed {
        logic [TS_WIDTH-1:0]    ts;
        logic [CNT_WIDTH-1:0]   seq;
        logic [SCORE_WIDTH-1:0] major;
        logic [SCORE_WIDTH-1:0] minor;
    } rec_t;

    logic [TS_WIDTH-1:0]  r_ts;
    logic [CNT_WIDTH-1:0] r_decision_count;
    logic [CNT_WIDTH-1:0] r_attack_count;
    logic [CNT_WIDTH-1:0] r_drop_count;
    alarm_state_e         r_state;
    logic [TMR_W-1:0]     r_timer;
    logic [HIT_W-1:0]     r_hits;

    logic                 w_decision;
    logic                 w_attack;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_empty;
    logic [HIT_W-1:0]     w_hits_next;
    rec_t                 w_push_rec;
    rec_t                 w_head;

    // Anything presented during a clear cycle is discarded.
    assign w_decision  = in_valid && !clear;
    assign w_attack    = w_decision && in_attack;
    assign w_drop      = w_attack && w_full && !rec_ready;
    assign w_hits_next = r_hits + HIT_W'(1);

    assign w_push_rec.ts    = r_ts;
    assign w_push_rec.seq   = r_attack_count;
    assign w_push_rec.major = in_major_score;
    assign w_push_rec.minor = in_minor_score;

    nids_alert_fifo #(
        .rec_t (rec_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (clear),
        .i_push      (w_attack),
        .i_push_data (w_push_rec),
        .i_pop       (rec_ready),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (fifo_level)
    );

    assign rec_valid      = !w_empty;
    assign rec_timestamp  = w_head.ts;
    assign rec_seq        = w_head.seq;
    assign rec_major      = w_head.major;
    assign rec_minor      = w_head.minor;
    assign decision_count = r_decision_count;
    assign attack_count   = r_attack_count;
    assign drop_count     = r_drop_count;
    assign alarm          = (r_state == ALARM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_WIDTH'(1);
        end
    end

    // Statistics saturate at all-ones so a long capture never reports a wrapped total.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_decision_count <= '0;
            r_attack_count   <= '0;
            r_drop_count     <= '0;
        end else if (clear) begin
            r_decision_count <= '0;
            r_attack_count   <= '0;
            r_drop_count     <= '0;
        end else begin
            if (w_decision && (r_decision_count != '1)) begin
                r_decision_count <= r_decision_count + CNT_WIDTH'(1);
            end
            if (w_attack && (r_attack_count != '1)) begin
                r_attack_count <= r_attack_count + CNT_WIDTH'(1);
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + CNT_WIDTH'(1);
            end
        end
    end

    // The COUNT window is anchored at its first attack; ALARM restarts its quiet timer on every attack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_hits  <= '0;
        end else if (clear) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_hits  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_attack) begin
                        r_timer <= TMR_RELOAD;
                        if (ALARM_THRESHOLD == 1) begin
                            r_state <= ALARM;
                            r_hits  <= '0;
                        end else begin
                            r_state <= COUNT;
                            r_hits  <= HIT_W'(1);
                        end
                    end
                end
                COUNT: begin
                    if (w_attack) begin
                        if (w_hits_next == HIT_W'(ALARM_THRESHOLD)) begin
                            r_state <= ALARM;
                            r_timer <= TMR_RELOAD;
                            r_hits  <= '0;
                        end else begin
                            r_hits  <= w_hits_next;
                            r_timer <= (r_timer != '0) ? r_timer - TMR_W'(1) : r_timer;
                        end
                    end else if (r_timer == '0) begin
                        r_state <= IDLE;
                        r_hits  <= '0;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                ALARM: begin
                    if (w_attack) begin
                        r_timer <= TMR_RELOAD;
                    end else if (r_timer == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_timer <= '0;
                    r_hits  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nids_alert_manager.sv
// Self-checking bench for nids_alert_manager: directed table, multi-cycle corner sequences and random traffic against a queue/time model.
module tb_nids_alert_manager;

    localparam int DEPTH  = 16;
    localparam int WIN    = 1024;
    localparam int THRESH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        inValid = 1'b0;
    logic        inAttack = 1'b0;
    logic [31:0] inMajor = '0;
    logic [31:0] inMinor = '0;
    logic        recReady = 1'b0;
    logic        recValid;
    logic [31:0] recTimestamp;
    logic [31:0] recSeq;
    logic [31:0] recMajor;
    logic [31:0] recMinor;
    logic [4:0]  fifoLevel;
    logic [31:0] decisionCount;
    logic [31:0] attackCount;
    logic [31:0] dropCount;
    logic        alarm;

    nids_alert_manager #(
        .SCORE_WIDTH     (32),
        .TS_WIDTH        (32),
        .CNT_WIDTH       (32),
        .FIFO_DEPTH      (DEPTH),
        .WINDOW_CYCLES   (WIN),
        .ALARM_THRESHOLD (THRESH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .in_valid       (inValid),
        .in_attack      (inAttack),
        .in_major_score (inMajor),
        .in_minor_score (inMinor),
        .rec_valid      (recValid),
        .rec_ready      (recReady),
        .rec_timestamp  (recTimestamp),
        .rec_seq        (recSeq),
        .rec_major      (recMajor),
        .rec_minor      (recMinor),
        .fifo_level     (fifoLevel),
        .decision_count (decisionCount),
        .attack_count   (attackCount),
        .drop_count     (dropCount),
        .alarm          (alarm)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: records as a queue, alarm tracked by absolute cycle times.
    typedef struct {
        logic [31:0] ts;
        logic [31:0] seq;
        logic [31:0] maj;
        logic [31:0] mn;
    } recModel_t;

    recModel_t   q[$];
    logic [31:0] mDec;
    logic [31:0] mAtk;
    logic [31:0] mDrop;
    longint      mCycle;
    bit          mInWindow;
    bit          mAlarm;
    int          mHits;
    longint      mWinStart;
    longint      mLastAtk;

    typedef struct {
        logic        v;
        logic        a;
        logic [31:0] maj;
        logic [31:0] mn;
        logic        rdy;
        logic        expValid;
        logic [31:0] expTs;
        logic [31:0] expSeq;
        logic [31:0] expMaj;
        logic [31:0] expMin;
        logic [4:0]  expLevel;
        logic [31:0] expDec;
        logic [31:0] expAtk;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [31:0] satInc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    function automatic vec_t mkVec(input logic v, a, input logic [31:0] maj, mn, input logic rdy,
                                   input logic ev, input logic [31:0] ets, eseq, emaj, emin,
                                   input logic [4:0] elev, input logic [31:0] edec, eatk);
        vec_t r;
        r.v = v; r.a = a; r.maj = maj; r.mn = mn; r.rdy = rdy;
        r.expValid = ev; r.expTs = ets; r.expSeq = eseq; r.expMaj = emaj; r.expMin = emin;
        r.expLevel = elev; r.expDec = edec; r.expAtk = eatk;
        return r;
    endfunction

    task automatic modelReset();
        q.delete();
        mDec = '0; mAtk = '0; mDrop = '0;
        mCycle = 0;
        mInWindow = 1'b0; mAlarm = 1'b0; mHits = 0;
        mWinStart = 0; mLastAtk = 0;
    endtask

    task automatic modelStep(input logic v, a, input logic [31:0] maj, mn, input logic rdy, clr);
        recModel_t r;
        bit atk;
        if (clr) begin
            q.delete();
            mDec = '0; mAtk = '0; mDrop = '0;
            mInWindow = 1'b0; mAlarm = 1'b0; mHits = 0;
        end else begin
            atk = v && a;
            if (rdy && q.size() > 0) void'(q.pop_front());
            if (v) mDec = satInc(mDec);
            if (atk) begin
                r.ts = mCycle[31:0]; r.seq = mAtk; r.maj = maj; r.mn = mn;
                if (q.size() < DEPTH) q.push_back(r);
                else mDrop = satInc(mDrop);
                mAtk = satInc(mAtk);
            end
            if (atk) begin
                if (mAlarm) begin
                    mLastAtk = mCycle;
                end else if (mInWindow) begin
                    mHits++;
                    if (mHits >= THRESH) begin
                        mAlarm = 1'b1; mInWindow = 1'b0; mLastAtk = mCycle;
                    end
                end else if (THRESH == 1) begin
                    mAlarm = 1'b1; mLastAtk = mCycle;
                end else begin
                    mInWindow = 1'b1; mHits = 1; mWinStart = mCycle;
                end
            end else begin
                if (mAlarm && mCycle >= mLastAtk + WIN) mAlarm = 1'b0;
                if (mInWindow && mCycle >= mWinStart + WIN) mInWindow = 1'b0;
            end
        end
        mCycle++;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        recModel_t h;
        logic hv;
        hv = (q.size() > 0);
        if (hv) h = q[0];
        else begin
            h.ts = '0; h.seq = '0; h.maj = '0; h.mn = '0;
        end
        checkOutput({tag, ".recValid"}, recValid, hv);
        checkOutput({tag, ".recTs"}, recTimestamp, h.ts);
        checkOutput({tag, ".recSeq"}, recSeq, h.seq);
        checkOutput({tag, ".recMajor"}, recMajor, h.maj);
        checkOutput({tag, ".recMinor"}, recMinor, h.mn);
        checkOutput({tag, ".level"}, fifoLevel, q.size());
        checkOutput({tag, ".decisions"}, decisionCount, mDec);
        checkOutput({tag, ".attacks"}, attackCount, mAtk);
        checkOutput({tag, ".drops"}, dropCount, mDrop);
        checkOutput({tag, ".alarm"}, alarm, mAlarm);
    endtask

    // Drives one cycle of inputs, advances the model on the edge, and returns #1 after it.
    task automatic applyStimulus(input logic v, a, input logic [31:0] maj, mn, input logic rdy, clr);
        inValid = v; inAttack = a; inMajor = maj; inMinor = mn; recReady = rdy; clear = clr;
        @(posedge clk);
        modelStep(v, a, maj, mn, rdy, clr);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        bit alarmSeen;
        int vRate, aRate, rRate;
        int rates[6][3] = '{'{60, 1, 50}, '{90, 40, 10}, '{70, 3, 80},
                            '{50, 0, 50}, '{100, 20, 90}, '{80, 2, 30}};

        for (int i = 0; i < 10; i++) vecs[i] = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[10] = mkVec(1, 1, 32'h100, 32'h20, 0, 1, 10, 0, 32'h100, 32'h20, 1, 1, 1);
        vecs[11] = mkVec(1, 0, 32'h5,   32'h6,  0, 1, 10, 0, 32'h100, 32'h20, 1, 2, 1);
        vecs[12] = mkVec(1, 1, 32'h300, 32'h40, 1, 1, 12, 1, 32'h300, 32'h40, 1, 3, 2);
        vecs[13] = mkVec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 2);
        vecs[14] = mkVec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 2);
        vecs[15] = mkVec(0, 1, 32'h7, 32'h8, 0, 0, 0, 0, 0, 0, 0, 3, 2);

        modelReset();
        #2 rst = 1'b1;
        #1 checkModel("rst.assert");
        @(posedge clk); #1;
        checkModel("rst.hold");
        rst = 1'b0;
        checkModel("rst.release");

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].v, vecs[i].a, vecs[i].maj, vecs[i].mn, vecs[i].rdy, 1'b0);
            checkOutput($sformatf("vec%0d.recValid", i), recValid, vecs[i].expValid);
            checkOutput($sformatf("vec%0d.recTs", i), recTimestamp, vecs[i].expTs);
            checkOutput($sformatf("vec%0d.recSeq", i), recSeq, vecs[i].expSeq);
            checkOutput($sformatf("vec%0d.recMajor", i), recMajor, vecs[i].expMaj);
            checkOutput($sformatf("vec%0d.recMinor", i), recMinor, vecs[i].expMin);
            checkOutput($sformatf("vec%0d.level", i), fifoLevel, vecs[i].expLevel);
            checkOutput($sformatf("vec%0d.decisions", i), decisionCount, vecs[i].expDec);
            checkOutput($sformatf("vec%0d.attacks", i), attackCount, vecs[i].expAtk);
        end
        checkModel("vecEnd");

        // Overflow: 17 attacks with no reader, then a pop coinciding with a push on a full FIFO.
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b1, 32'h1000 + i, 32'h2000 + i, 1'b0, 1'b0);
        checkOutput("ovf.level", fifoLevel, 16);
        checkOutput("ovf.drops", dropCount, 1);
        checkOutput("ovf.attacks", attackCount, 17);
        checkOutput("ovf.head0", recSeq, 0);
        applyStimulus(1'b1, 1'b1, 32'hAAA, 32'hBBB, 1'b1, 1'b0);
        checkOutput("ovf.levelHeld", fifoLevel, 16);
        checkOutput("ovf.dropsHeld", dropCount, 1);
        for (int k = 1; k < 16; k++) begin
            checkOutput($sformatf("ovf.drainSeq%0d", k), recSeq, k);
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        end
        checkOutput("ovf.lastSeq", recSeq, 17);
        checkOutput("ovf.lastMajor", recMajor, 32'hAAA);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("ovf.emptyValid", recValid, 0);
        checkModel("ovfEnd");

        // Alarm raise: four attacks 100 cycles apart, then a quiet period of exactly one window.
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1'b1, 1'b1, n, n, 1'b1, 1'b0);
            if (n < 3) begin
                checkOutput($sformatf("raise.early%0d", n), alarm, 0);
                idleCycles(99);
            end
        end
        checkOutput("raise.rise", alarm, 1);
        idleCycles(WIN - 1);
        checkOutput("raise.holdLast", alarm, 1);
        idleCycles(1);
        checkOutput("raise.fall", alarm, 0);
        checkModel("raiseEnd");

        // Alarm miss: attacks too sparse to share a window.
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        alarmSeen = 1'b0;
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1'b1, 1'b1, n, n, 1'b1, 1'b0);
            alarmSeen |= alarm;
            if (n < 3) begin
                for (int i = 0; i < 1099; i++) begin
                    idleCycles(1);
                    alarmSeen |= alarm;
                end
            end
        end
        checkOutput("miss.neverAlarm", alarmSeen, 0);
        checkOutput("miss.attacks", attackCount, 4);
        checkModel("missEnd");

        // Clear with records queued, alarm raised and a coincident attack.
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 32'h50 + i, 32'h60 + i, 1'b0, 1'b0);
        checkOutput("clr.preAlarm", alarm, 1);
        checkOutput("clr.preLevel", fifoLevel, 5);
        applyStimulus(1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 1'b0, 1'b1);
        checkOutput("clr.decisions", decisionCount, 0);
        checkOutput("clr.attacks", attackCount, 0);
        checkOutput("clr.drops", dropCount, 0);
        checkOutput("clr.recValid", recValid, 0);
        checkOutput("clr.level", fifoLevel, 0);
        checkOutput("clr.alarm", alarm, 0);
        applyStimulus(1'b1, 1'b1, 32'h77, 32'h88, 1'b0, 1'b0);
        checkModel("clr.after");

        // Random traffic in segments of differing attack density and reader availability.
        for (int s = 0; s < 6; s++) begin
            vRate = rates[s][0]; aRate = rates[s][1]; rRate = rates[s][2];
            for (int i = 0; i < 500; i++) begin
                applyStimulus(($urandom_range(0, 99) < vRate), ($urandom_range(0, 99) < aRate),
                              $urandom, $urandom, ($urandom_range(0, 99) < rRate),
                              ($urandom_range(0, 999) == 0));
                checkModel($sformatf("rnd%0d", s));
            end
        end

        // Reset in the middle of traffic.
        inValid = 1'b0; inAttack = 1'b0; recReady = 1'b0; clear = 1'b0;
        rst = 1'b1;
        modelReset();
        #1 checkModel("midRst.assert");
        @(posedge clk); #1;
        checkModel("midRst.hold");
        rst = 1'b0;
        checkModel("midRst.release");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 30),
                          $urandom, $urandom, ($urandom_range(0, 99) < 40), 1'b0);
            checkModel("postRst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nids_alert_manager.md
# nids_alert_manager

Downstream consumer of the PCA detection pipeline. It accepts one detection result per `in_valid` pulse, keeps decision, attack and drop statistics, and timestamps each attack. Attack records are buffered in a FIFO for the HPS to read over a valid/ready interface. A windowed alarm FSM raises a sticky-until-quiet `alarm` when attacks cluster in time.

## Interface
- `SCORE_WIDTH`, 32: width of the major/minor PCA scores.
- `TS_WIDTH`, 32: width of the free-running timestamp.
- `CNT_WIDTH`, 32: width of the statistics counters and the sequence number.
- `FIFO_DEPTH`, 16: record buffer depth; must be a power of two, at least 2.
- `WINDOW_CYCLES`, 1024: length of the alarm window and of the quiet period, in cycles.
- `ALARM_THRESHOLD`, 4: number of attacks within one window that raises the alarm; at least 1.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous clear of counters, FIFO and FSM.
- `in_valid` in 1: a detection result is present this cycle.
- `in_attack` in 1: the detector flagged this result as an attack.
- `in_major_score` in SCORE_WIDTH: major-subspace score.
- `in_minor_score` in SCORE_WIDTH: minor-subspace score.
- `rec_valid` out 1: a record is available at the FIFO head.
- `rec_ready` in 1: the HPS accepts the head record.
- `rec_timestamp` out TS_WIDTH: timestamp of the head record.
- `rec_seq` out CNT_WIDTH: sequence number of the head record.
- `rec_major` out SCORE_WIDTH: major score of the head record.
- `rec_minor` out SCORE_WIDTH: minor score of the head record.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: number of stored records.
- `decision_count` out CNT_WIDTH: number of `in_valid` results accepted.
- `attack_count` out CNT_WIDTH: number of results with `in_attack` set.
- `drop_count` out CNT_WIDTH: number of attack records lost to a full FIFO.
- `alarm` out 1: alarm state indicator.

## Operation
- **Timestamp:** `ts` is a free-running counter. It increments every cycle, wraps modulo 2^TS_WIDTH, and is cleared by `rst` only.
- **Decisions:** each `in_valid` cycle increments `decision_count`.
- **Attacks:** if `in_attack` is also set, the cycle is an attack event.
  - It increments `attack_count`.
  - It pushes the record {`ts`, seq = `attack_count` before increment, major, minor}.
- **Saturation:** all three counters saturate at all-ones and never wrap.
- **FIFO:** first-word fall-through. The head record is visible while `rec_valid`=1. A pop occurs on `rec_valid && rec_ready`.
- **Full FIFO:**
  - A push with no simultaneous pop is dropped: `drop_count` increments, and `attack_count` still increments.
  - A push with a simultaneous pop succeeds, and the level is unchanged.
- **Empty FIFO:** `rec_ready` has no effect.
- **Alarm FSM** (`alarm` = 1 only in ALARM; the window timer is a down-counter):
  - **IDLE:** an attack moves to COUNT with hits=1 and timer=WINDOW_CYCLES-1. If ALARM_THRESHOLD=1, it goes directly to ALARM instead.
  - **COUNT:** each attack increments hits. When hits reaches ALARM_THRESHOLD, the FSM moves to ALARM and the timer reloads to WINDOW_CYCLES-1. If the timer reaches 0 without an attack, the FSM returns to IDLE.
  - **ALARM:** each attack reloads the timer to WINDOW_CYCLES-1. When the timer reaches 0 with no attack, the FSM returns to IDLE.
- **Clear:** `clear` has priority over everything in the same cycle.
  - It zeroes all counters.
  - It flushes the FIFO, so `rec_valid`=0 next cycle.
  - It sends the FSM to IDLE.
  - Any input in the `clear` cycle is discarded and not counted.
  - `ts` is not cleared.
- **Reset mid-operation:** immediate return to reset values, and FIFO contents are lost.

## Timing
- **Reset values:** all outputs are 0. The FSM is in IDLE, `ts`=0, and the FIFO is empty.
- **Counters:** all counters and `fifo_level` update on the clock edge after the triggering cycle (latency 1).
- **Record availability:** a push into an empty FIFO makes `rec_valid`=1 and the record fields valid on the next cycle.
- **Pop:** the next head is presented on the cycle after a pop.
- **Alarm latency:** `alarm` rises the cycle after the threshold-reaching attack. It falls the cycle after the timer expires, i.e. WINDOW_CYCLES cycles after the last attack.
- **Input stream:** there is no backpressure toward the detector. Input is accepted every cycle.

## Structure
- Shared package `nids_pkg` holds:
  - `alert_rec_t`, a packed struct of ts, seq, major and minor;
  - `alarm_state_e`, with IDLE, COUNT and ALARM.
- Sub-module `nids_alert_fifo` provides a parameterised FWFT FIFO of `alert_rec_t`. It has push, pop, full, empty, level and a synchronous flush.
- Top-level logic contains the counters, the timestamp and the alarm FSM.

## Test plan
- **Reset:** assert `rst` mid-stream. Every output reads 0 while reset is asserted and on the first cycle after release.
- **Single attack:** one `in_valid`+`in_attack` pulse at `ts`=10 with major=0x100, minor=0x20. Next cycle: `rec_valid`=1, ts=10, seq=0, major=0x100, minor=0x20, `attack_count`=1, `decision_count`=1, `fifo_level`=1.
- **Overflow:** with `rec_ready`=0, apply 17 attacks. Expect `fifo_level`=16 and `drop_count`=1. Then pop while pushing on a full FIFO: level stays 16 and `drop_count` stays 1. Drain order gives seq 0..15, then the seq of the simultaneous push.
- **Alarm raise:** 4 attacks spaced 100 cycles apart. `alarm` rises the cycle after the 4th attack, then falls exactly 1024 cycles after that attack.
- **Alarm miss:** 4 attacks spaced 1100 cycles apart. `alarm` stays 0 throughout, and `attack_count`=4.
- **Clear:** assert `clear` with 5 records queued and the FSM in ALARM, while `in_valid`+`in_attack` are also asserted. Next cycle: all counters 0, `rec_valid`=0, `alarm`=0, and the coincident input is not counted.
